riscv_mini_sequencer: RTL and testbench

RISCV_MINI_SEQUENCER -- requirements
Module: riscv_mini_sequencer

---
 rtl/riscv_mini_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_riscv_mini_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mini_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : riscv_mini_sequencer
// Description : Holds a small program of 16-bit instructions and streams it to
//               an attached mini core, one entry per cycle. Captures the core
//               result for output instructions into a one-deep result
//               register, and stalls when that register is still unread.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   load_valid   host offers load_byte
//   load_byte    program byte, low byte of an entry first
//   load_ready   byte accepted this cycle
//   clear        discard stored program (IDLE only)
//   start        run the stored program
//   busy         high while running
//   done         one-cycle pulse after the last entry issues
//   prog_len     number of complete stored entries
//   instr_out    instruction to the core
//   core_result  core output, combinational on instr_out
//   res_valid    res_data holds an unread result
//   res_data     captured result
//   res_ready    consumer takes res_data
// ============================================================================
module riscv_mini_sequencer #(
    parameter int          DEPTH = 16,
    parameter logic [15:0] NOP   = 16'h2003
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_valid,
    input  logic [7:0]  load_byte,
    output logic        load_ready,
    input  logic        clear,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [4:0]  prog_len,
    output logic [15:0] instr_out,
    input  logic [7:0]  core_result,
    output logic        res_valid,
    output logic [7:0]  res_data,
    input  logic        res_ready
);

    localparam int         AW      = $clog2(DEPTH);
    localparam logic [4:0] C_DEPTH = 5'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic [4:0]      prog_len_q, prog_len_d;
    logic            phase_q, phase_d;
    logic [7:0]      low_q, low_d;
    logic            res_valid_q, res_valid_d;
    logic [7:0]      res_data_q, res_data_d;
    logic            mem_we;

    logic [15:0]     mem_q [DEPTH];

    logic [15:0]     cur;
    logic            is_out;
    logic            stall;
    logic            last;
    logic            accept;

    assign cur        = mem_q[pc_q];
    // Output instruction: opcode 11 with funct3 000, 011 or 111.
    assign is_out     = (cur[1:0] == 2'b11) &&
                        ((cur[15:13] == 3'b000) || (cur[15:13] == 3'b011) ||
                         (cur[15:13] == 3'b111));
    // A pending result may be overwritten only if it is taken this same cycle.
    assign stall      = is_out && res_valid_q && !res_ready;
    assign last       = ({{(5-AW){1'b0}}, pc_q} == (prog_len_q - 5'd1));
    assign load_ready = (state_q == S_IDLE) && (prog_len_q < C_DEPTH);
    assign accept     = load_valid && load_ready && !clear;

    assign prog_len   = prog_len_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        prog_len_d  = prog_len_q;
        phase_d     = phase_q;
        low_d       = low_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        mem_we      = 1'b0;
        instr_out   = NOP;
        busy        = 1'b0;
        done        = 1'b0;

        // Consumer handshake; a capture in the same cycle overrides below.
        if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (clear) begin
                    prog_len_d = 5'd0;
                    phase_d    = 1'b0;
                end else begin
                    if (accept) begin
                        if (!phase_q) begin
                            low_d   = load_byte;
                            phase_d = 1'b1;
                        end else begin
                            mem_we     = 1'b1;
                            prog_len_d = prog_len_q + 5'd1;
                            phase_d    = 1'b0;
                        end
                    end
                    // Starting drops any half-loaded entry.
                    if (start && (prog_len_q != 5'd0)) begin
                        state_d = S_RUN;
                        pc_d    = '0;
                        phase_d = 1'b0;
                    end
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (!stall) begin
                    instr_out = cur;
                    if (is_out) begin
                        res_data_d  = core_result;
                        res_valid_d = 1'b1;
                    end
                    if (last) begin
                        pc_d    = '0;
                        state_d = S_DONE;
                    end else begin
                        pc_d = pc_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            prog_len_q  <= 5'd0;
            phase_q     <= 1'b0;
            low_q       <= 8'h00;
            res_valid_q <= 1'b0;
            res_data_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            prog_len_q  <= prog_len_d;
            phase_q     <= phase_d;
            low_q       <= low_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    // Program storage carries no reset; contents are meaningless until loaded.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[prog_len_q[AW-1:0]] <= {load_byte, low_q};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_riscv_mini_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_mini_sequencer
// Description : Directed self-checking bench for riscv_mini_sequencer.
//               The attached core is modelled as
//               core_result = instr[15:8] + instr[7:0] + 8'h27.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_mini_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_valid = 1'b0;
    logic [7:0]  load_byte = 8'h00;
    logic        load_ready;
    logic        clear = 1'b0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic [4:0]  prog_len;
    logic [15:0] instr_out;
    logic [7:0]  core_result;
    logic        res_valid;
    logic [7:0]  res_data;
    logic        res_ready = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign core_result = instr_out[15:8] + instr_out[7:0] + 8'h27;

    riscv_mini_sequencer #(.DEPTH(16), .NOP(16'h2003)) dut (
        .clk(clk), .rst(rst),
        .load_valid(load_valid), .load_byte(load_byte), .load_ready(load_ready),
        .clear(clear), .start(start), .busy(busy), .done(done),
        .prog_len(prog_len), .instr_out(instr_out), .core_result(core_result),
        .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put_byte(input logic [7:0] b);
        load_valid = 1'b1;
        load_byte  = b;
        step();
        load_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total++; if (prog_len !== 5'd0)      begin bad++; $display("FAIL rst_prog_len got %h exp 00", prog_len); end
        total++; if (busy !== 1'b0)          begin bad++; $display("FAIL rst_busy got %b exp 0", busy); end
        total++; if (done !== 1'b0)          begin bad++; $display("FAIL rst_done got %b exp 0", done); end
        total++; if (res_valid !== 1'b0)     begin bad++; $display("FAIL rst_res_valid got %b exp 0", res_valid); end
        total++; if (res_data !== 8'h00)     begin bad++; $display("FAIL rst_res_data got %h exp 00", res_data); end
        total++; if (instr_out !== 16'h2003) begin bad++; $display("FAIL rst_instr got %h exp 2003", instr_out); end
        total++; if (load_ready !== 1'b1)    begin bad++; $display("FAIL rst_load_ready got %b exp 1", load_ready); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic_run();
        put_byte(8'h05); put_byte(8'h00); put_byte(8'h27); put_byte(8'hE0);
        total++; if (prog_len !== 5'd2) begin bad++; $display("FAIL basic_len got %h exp 02", prog_len); end
        start = 1'b1; step(); start = 1'b0;
        total++; if (instr_out !== 16'h0005) begin bad++; $display("FAIL basic_i0 got %h exp 0005", instr_out); end
        total++; if (busy !== 1'b1)          begin bad++; $display("FAIL basic_busy0 got %b exp 1", busy); end
        step();
        total++; if (instr_out !== 16'hE027) begin bad++; $display("FAIL basic_i1 got %h exp E027", instr_out); end
        total++; if (busy !== 1'b1)          begin bad++; $display("FAIL basic_busy1 got %b exp 1", busy); end
        step();
        total++; if (done !== 1'b1)          begin bad++; $display("FAIL basic_done got %b exp 1", done); end
        total++; if (busy !== 1'b0)          begin bad++; $display("FAIL basic_busy_done got %b exp 0", busy); end
        total++; if (instr_out !== 16'h2003) begin bad++; $display("FAIL basic_nop_done got %h exp 2003", instr_out); end
        // E027 is an output instruction: E0 + 27 + 27 = 2E
        total++; if (res_data !== 8'h2E)     begin bad++; $display("FAIL basic_res got %h exp 2E", res_data); end
        step();
        total++; if (done !== 1'b0)          begin bad++; $display("FAIL basic_done_end got %b exp 0", done); end
        res_ready = 1'b1; step(); res_ready = 1'b0;
        total++; if (res_valid !== 1'b0)     begin bad++; $display("FAIL basic_hs got %b exp 0", res_valid); end
    endtask

    task automatic test_result_capture();
        do_clear();
        total++; if (prog_len !== 5'd0) begin bad++; $display("FAIL cap_clear got %h exp 00", prog_len); end
        put_byte(8'h05); put_byte(8'h00); put_byte(8'h03); put_byte(8'h00);
        start = 1'b1; step(); start = 1'b0;
        step();
        total++; if (core_result !== 8'h2A) begin bad++; $display("FAIL cap_core got %h exp 2A", core_result); end
        step();
        total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL cap_valid got %b exp 1", res_valid); end
        total++; if (res_data !== 8'h2A) begin bad++; $display("FAIL cap_data got %h exp 2A", res_data); end
        res_ready = 1'b1; step(); res_ready = 1'b0;
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL cap_hs got %b exp 0", res_valid); end
    endtask

    task automatic test_stall();
        do_clear();
        // 0013 -> 3A, 6007 -> 8E, E00B -> 12
        put_byte(8'h13); put_byte(8'h00); put_byte(8'h07); put_byte(8'h60);
        put_byte(8'h0B); put_byte(8'hE0);
        res_ready = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        total++; if (instr_out !== 16'h0013) begin bad++; $display("FAIL stall_i0 got %h exp 0013", instr_out); end
        step();
        total++; if (res_data !== 8'h3A)     begin bad++; $display("FAIL stall_r0 got %h exp 3A", res_data); end
        total++; if (instr_out !== 16'h2003) begin bad++; $display("FAIL stall_nop1 got %h exp 2003", instr_out); end
        step();
        total++; if (instr_out !== 16'h2003) begin bad++; $display("FAIL stall_nop2 got %h exp 2003", instr_out); end
        total++; if (busy !== 1'b1)          begin bad++; $display("FAIL stall_busy got %b exp 1", busy); end
        res_ready = 1'b1; #1;
        total++; if (instr_out !== 16'h6007) begin bad++; $display("FAIL stall_rel1 got %h exp 6007", instr_out); end
        step();
        total++; if (res_data !== 8'h8E)     begin bad++; $display("FAIL stall_r1 got %h exp 8E", res_data); end
        total++; if (res_valid !== 1'b1)     begin bad++; $display("FAIL stall_v1 got %b exp 1", res_valid); end
        total++; if (instr_out !== 16'hE00B) begin bad++; $display("FAIL stall_rel2 got %h exp E00B", instr_out); end
        step();
        total++; if (res_data !== 8'h12)     begin bad++; $display("FAIL stall_r2 got %h exp 12", res_data); end
        total++; if (done !== 1'b1)          begin bad++; $display("FAIL stall_done got %b exp 1", done); end
        step();
        res_ready = 1'b0;
        total++; if (res_valid !== 1'b0)     begin bad++; $display("FAIL stall_drain got %b exp 0", res_valid); end
    endtask

    task automatic test_full_load();
        logic [15:0] exp_i;
        do_clear();
        res_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL full_ready%0d got %b exp 1", i, load_ready); end
            put_byte(8'(i));
        end
        total++; if (prog_len !== 5'd16)  begin bad++; $display("FAIL full_len got %h exp 10", prog_len); end
        total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL full_ready_end got %b exp 0", load_ready); end
        put_byte(8'hFF);
        total++; if (prog_len !== 5'd16)  begin bad++; $display("FAIL full_33rd got %h exp 10", prog_len); end
        start = 1'b1; step(); start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            exp_i = {8'(2*k+1), 8'(2*k)};
            total++; if (instr_out !== exp_i) begin bad++; $display("FAIL full_i%0d got %h exp %h", k, instr_out, exp_i); end
            clear = (k == 5);
            step();
        end
        clear = 1'b0;
        total++; if (done !== 1'b1)       begin bad++; $display("FAIL full_done got %b exp 1", done); end
        total++; if (prog_len !== 5'd16)  begin bad++; $display("FAIL full_clear_run got %h exp 10", prog_len); end
        step();
        res_ready = 1'b0;
        do_clear();
        total++; if (prog_len !== 5'd0)   begin bad++; $display("FAIL full_clear got %h exp 00", prog_len); end
        total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL full_ready_clr got %b exp 1", load_ready); end
    endtask

    task automatic test_reset_mid_run();
        put_byte(8'h03); put_byte(8'h00); put_byte(8'h05); put_byte(8'h00);
        put_byte(8'h05); put_byte(8'h00);
        start = 1'b1; step(); start = 1'b0;
        step();
        total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid got %b exp 1", res_valid); end
        rst = 1'b1; #1;
        total++; if (busy !== 1'b0)          begin bad++; $display("FAIL mid_busy got %b exp 0", busy); end
        total++; if (instr_out !== 16'h2003) begin bad++; $display("FAIL mid_instr got %h exp 2003", instr_out); end
        total++; if (res_valid !== 1'b0)     begin bad++; $display("FAIL mid_valid got %b exp 0", res_valid); end
        total++; if (prog_len !== 5'd0)      begin bad++; $display("FAIL mid_len got %h exp 00", prog_len); end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_ignored_start();
        start = 1'b1; step(); start = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign_busy got %b exp 0", busy); end
        step();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL ign_done got %b exp 0", done); end
        // clear wins over a simultaneous load byte
        load_valid = 1'b1; load_byte = 8'h77; clear = 1'b1;
        step();
        load_valid = 1'b0; clear = 1'b0;
        put_byte(8'h05); put_byte(8'h01); put_byte(8'h05); put_byte(8'h02);
        put_byte(8'h05); put_byte(8'h03);
        total++; if (prog_len !== 5'd3) begin bad++; $display("FAIL ign_len got %h exp 03", prog_len); end
        start = 1'b1; step();
        total++; if (instr_out !== 16'h0105) begin bad++; $display("FAIL ign_i0 got %h exp 0105", instr_out); end
        step(); start = 1'b0;
        total++; if (instr_out !== 16'h0205) begin bad++; $display("FAIL ign_i1 got %h exp 0205", instr_out); end
        step();
        total++; if (instr_out !== 16'h0305) begin bad++; $display("FAIL ign_i2 got %h exp 0305", instr_out); end
        step();
        total++; if (done !== 1'b1) begin bad++; $display("FAIL ign_done_end got %b exp 1", done); end
        step();
        // program retained: re-run starts again at entry 0
        start = 1'b1; step(); start = 1'b0;
        total++; if (instr_out !== 16'h0105) begin bad++; $display("FAIL rerun_i0 got %h exp 0105", instr_out); end
        step(); step(); step();
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_result_capture();
        test_stall();
        test_full_load();
        test_reset_mid_run();
        test_ignored_start();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
